// File: rtl/sp1_adder_comp_pkg.sv
// -----------------------------------------------------------------------------
// sp1_adder_comp_pkg
//   Shared constants for the SP1 adder/compare operator.
//   SP1_DW_DEFAULT : default operand/result width used by the operator
//                    and its combinational core.
//   SP1_DW_MAX     : widest operand width the operator is meant to be
//                    built with.
//   Optional feature macro used by the operator files: SP1_ADDER_COMP_SUB_EN.
// -----------------------------------------------------------------------------
package sp1_adder_comp_pkg;

  localparam int SP1_DW_DEFAULT = 32;
  localparam int SP1_DW_MAX     = 64;

endpackage : sp1_adder_comp_pkg

// File: rtl/sp1_adder_comp_core.sv
// -----------------------------------------------------------------------------
// sp1_adder_comp_core
//   Purely combinational arithmetic/compare core of the SP1 adder/compare
//   operator.
//   Optional feature macro: SP1_ADDER_COMP_SUB_EN (adds difference/borrow).
//
// Ports:
//   i_a0      in  DW  operand 0, unsigned
//   i_a1      in  DW  operand 1, unsigned
//   o_sum     out DW  a0 + a1 modulo 2^DW
//   o_carry   out 1   carry-out of a0 + a1
//   o_eq      out 1   a0 == a1
//   o_gt      out 1   a0 > a1, unsigned
//   o_diff    out DW  a0 - a1 modulo 2^DW     (SP1_ADDER_COMP_SUB_EN only)
//   o_borrow  out 1   borrow of a0 - a1       (SP1_ADDER_COMP_SUB_EN only)
// -----------------------------------------------------------------------------
module sp1_adder_comp_core
  import sp1_adder_comp_pkg::*;
#(
  parameter int DW = SP1_DW_DEFAULT
) (
  input  logic [DW-1:0] i_a0,
  input  logic [DW-1:0] i_a1,
  output logic [DW-1:0] o_sum,
  output logic          o_carry,
  output logic          o_eq,
  output logic          o_gt
`ifdef SP1_ADDER_COMP_SUB_EN
  ,
  output logic [DW-1:0] o_diff,
  output logic          o_borrow
`endif
);

  // Sum is formed one bit wider so the carry falls out as the top bit.
  logic [DW:0] w_sum_ext;

  assign w_sum_ext = {1'b0, i_a0} + {1'b0, i_a1};
  assign o_sum     = w_sum_ext[DW-1:0];
  assign o_carry   = w_sum_ext[DW];

  // Both operands are plain logic vectors, so the compare is unsigned;
  // the MSB is not treated as a sign bit.
  assign o_eq = (i_a0 == i_a1);
  assign o_gt = (i_a0 > i_a1);

`ifdef SP1_ADDER_COMP_SUB_EN
  // Independent subtractor: the extension bit wraps to 1 exactly when
  // a0 < a1. gt is deliberately not derived from this borrow.
  logic [DW:0] w_diff_ext;

  assign w_diff_ext = {1'b0, i_a0} - {1'b0, i_a1};
  assign o_diff     = w_diff_ext[DW-1:0];
  assign o_borrow   = w_diff_ext[DW];
`endif

endmodule : sp1_adder_comp_core

// File: rtl/sp1_adder_comp.sv
// -----------------------------------------------------------------------------
// sp1_adder_comp
//   Registered arithmetic/compare unit of the SP1 datapath operator library.
//   Each accepted operand pair yields, one cycle later, the unsigned sum with
//   carry-out, an equality flag and an unsigned greater-than flag, all
//   qualified by a single out_valid. No backpressure: one pair per cycle.
//   Optional feature macro: SP1_ADDER_COMP_SUB_EN (adds registered difference
//   d and borrow b with identical timing and reset behaviour).
//
// Ports:
//   clk        in  1   clock, all state on rising edge
//   rst        in  1   asynchronous reset, active-low
//   in_valid   in  1   operand pair valid this cycle
//   a0         in  DW  operand 0, unsigned
//   a1         in  DW  operand 1, unsigned
//   out_valid  out 1   registered results valid
//   y          out DW  registered a0 + a1 modulo 2^DW
//   c          out 1   registered carry-out of a0 + a1
//   eq         out 1   registered a0 == a1
//   gt         out 1   registered a0 > a1, unsigned
//   b          out 1   registered borrow of a0 - a1     (SP1_ADDER_COMP_SUB_EN)
//   d          out DW  registered a0 - a1 modulo 2^DW   (SP1_ADDER_COMP_SUB_EN)
// -----------------------------------------------------------------------------
module sp1_adder_comp
  import sp1_adder_comp_pkg::*;
#(
  parameter int DW = SP1_DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] a0,
  input  logic [DW-1:0] a1,
  output logic          out_valid,
  output logic [DW-1:0] y,
  output logic          c,
  output logic          eq,
  output logic          gt
`ifdef SP1_ADDER_COMP_SUB_EN
  ,
  output logic          b,
  output logic [DW-1:0] d
`endif
);

  logic [DW-1:0] w_sum;
  logic          w_carry;
  logic          w_eq;
  logic          w_gt;

  logic          r_vld_p1;
  logic [DW-1:0] r_sum_p1;
  logic          r_carry_p1;
  logic          r_eq_p1;
  logic          r_gt_p1;

`ifdef SP1_ADDER_COMP_SUB_EN
  logic [DW-1:0] w_diff;
  logic          w_borrow;
  logic [DW-1:0] r_diff_p1;
  logic          r_borrow_p1;
`endif

  sp1_adder_comp_core #(
    .DW (DW)
  ) u_core (
    .i_a0     (a0),
    .i_a1     (a1),
    .o_sum    (w_sum),
    .o_carry  (w_carry),
    .o_eq     (w_eq),
    .o_gt     (w_gt)
`ifdef SP1_ADDER_COMP_SUB_EN
    ,
    .o_diff   (w_diff),
    .o_borrow (w_borrow)
`endif
  );

  // ---- stage p0 -> p1 : result registers -----------------------------------
  // Valid follows in_valid every cycle; the data registers only load on an
  // accepted pair and otherwise keep their last value. Reset clears both
  // so the outputs read zero while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sum_p1   <= '0;
      r_carry_p1 <= 1'b0;
      r_eq_p1    <= 1'b0;
      r_gt_p1    <= 1'b0;
    end else if (in_valid) begin
      r_sum_p1   <= w_sum;
      r_carry_p1 <= w_carry;
      r_eq_p1    <= w_eq;
      r_gt_p1    <= w_gt;
    end
  end

`ifdef SP1_ADDER_COMP_SUB_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_diff_p1   <= '0;
      r_borrow_p1 <= 1'b0;
    end else if (in_valid) begin
      r_diff_p1   <= w_diff;
      r_borrow_p1 <= w_borrow;
    end
  end

  assign d = r_diff_p1;
  assign b = r_borrow_p1;
`endif

  assign out_valid = r_vld_p1;
  assign y         = r_sum_p1;
  assign c         = r_carry_p1;
  assign eq        = r_eq_p1;
  assign gt        = r_gt_p1;

endmodule : sp1_adder_comp

// File: tb/tb_sp1_adder_comp.sv
// -----------------------------------------------------------------------------
// tb_sp1_adder_comp
//   Self-checking bench for sp1_adder_comp at DW=8. Directed vectors for
//   reset, wrap, unsigned compare and streaming, followed by randomized
//   traffic checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_sp1_adder_comp;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] a0 = '0;
  logic [DW-1:0] a1 = '0;
  logic          out_valid;
  logic [DW-1:0] y;
  logic          c;
  logic          eq;
  logic          gt;
`ifdef SP1_ADDER_COMP_SUB_EN
  logic          b;
  logic [DW-1:0] d;
`endif

  int checks = 0;
  int errors = 0;

  // reference model state: what the outputs must show after each edge
  int m_vld = 0;
  int m_y   = 0;
  int m_c   = 0;
  int m_eq  = 0;
  int m_gt  = 0;
  int m_d   = 0;
  int m_b   = 0;

  sp1_adder_comp #(
    .DW (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a0        (a0),
    .a1        (a1),
    .out_valid (out_valid),
    .y         (y),
    .c         (c),
    .eq        (eq),
    .gt        (gt)
`ifdef SP1_ADDER_COMP_SUB_EN
    ,
    .b         (b),
    .d         (d)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_vld = 0; m_y = 0; m_c = 0; m_eq = 0; m_gt = 0; m_d = 0; m_b = 0;
  endtask

  // Arithmetic reference taken straight from the unsigned definitions.
  task automatic model_edge(input int v, input int x0, input int x1);
    int mod;
    mod = 1 << DW;
    if (rst == 1'b0) begin
      model_clear();
    end else if (v != 0) begin
      m_vld = 1;
      m_y   = (x0 + x1) % mod;
      m_c   = ((x0 + x1) >= mod) ? 1 : 0;
      m_eq  = (x0 == x1) ? 1 : 0;
      m_gt  = (x0 > x1) ? 1 : 0;
      m_d   = (x0 - x1 + mod) % mod;
      m_b   = (x0 < x1) ? 1 : 0;
    end else begin
      m_vld = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, longint'(out_valid), longint'(m_vld));
    chk({tag, ".y"},         longint'(y),         longint'(m_y));
    chk({tag, ".c"},         longint'(c),         longint'(m_c));
    chk({tag, ".eq"},        longint'(eq),        longint'(m_eq));
    chk({tag, ".gt"},        longint'(gt),        longint'(m_gt));
`ifdef SP1_ADDER_COMP_SUB_EN
    chk({tag, ".d"},         longint'(d),         longint'(m_d));
    chk({tag, ".b"},         longint'(b),         longint'(m_b));
`endif
  endtask

  // Apply one input cycle, let the edge happen, then compare 1 time unit later.
  task automatic step(input string tag, input int v, input int x0, input int x1);
    in_valid = v[0];
    a0 = x0[DW-1:0];
    a1 = x1[DW-1:0];
    @(posedge clk);
    model_edge(v, x0, x1);
    #1;
    check_outputs(tag);
  endtask

  function automatic int pick_operand();
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return (1 << DW) - 1;
      2:       return 1 << (DW - 1);
      3:       return (1 << (DW - 1)) - 1;
      default: return int'($urandom_range(0, (1 << DW) - 1));
    endcase
  endfunction

  initial begin
    // reset held low with live inputs: outputs must stay zero
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step("reset_hold", 1, 'h12, 'h34);

    // release away from the clock edge
    #2 rst = 1'b1;
    step("first_capture", 1, 'h12, 'h34);   // y=46 c=0 eq=0 gt=0

    // async reset mid-cycle must clear outputs before the next edge
    #2 rst = 1'b0;
    #1;
    model_clear();
    check_outputs("async_reset");
    #2 rst = 1'b1;
    step("post_reset_idle", 0, 'h55, 'h55);  // stays invalid, data still 0

    step("add_nocarry", 1, 'h12, 'h34);
    step("wrap_ff_01",  1, 'hff, 'h01);      // y=00 c=1 gt=1
    step("wrap_ff_ff",  1, 'hff, 'hff);      // y=fe c=1 eq=1
    step("zero_zero",   1, 'h00, 'h00);      // y=00 c=0 eq=1
    step("cmp_80_7f",   1, 'h80, 'h7f);      // gt=1 y=ff c=0
    step("cmp_7f_80",   1, 'h7f, 'h80);      // gt=0 eq=0

    // streaming then bubble; y must hold 05
    step("stream0", 1, 'h01, 'h01);
    step("stream1", 1, 'h02, 'h01);
    step("stream2", 1, 'h00, 'h05);
    step("bubble",  0, 'h99, 'h11);
    step("bubble2", 0, 'h01, 'h02);

    step("sub_05_07", 1, 'h05, 'h07);        // d=fe b=1
    step("sub_07_05", 1, 'h07, 'h05);        // d=02 b=0

    // randomized traffic with occasional bubbles
    for (int i = 0; i < 300; i++) begin
      int v;
      v = ($urandom_range(0, 3) != 0) ? 1 : 0;
      step("rand", v, pick_operand(), pick_operand());
    end

    // reset dropped mid-stream discards the in-flight result
    in_valid = 1'b1;
    a0 = 8'h40;
    a1 = 8'h41;
    #2 rst = 1'b0;
    #1;
    model_clear();
    check_outputs("midstream_reset");
    @(posedge clk);
    #1;
    check_outputs("midstream_reset_hold");
    #2 rst = 1'b1;
    step("after_release_idle", 0, 'h40, 'h41);
    step("after_release_cap",  1, 'h40, 'h41);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sp1_adder_comp
